// File: rtl/pwm_leds.sv
// rtl/pwm_leds.sv - memory-mapped multi-channel PWM controller with shadowed duty registers
// Duty values latch into per-channel shadows only at period wrap, so outputs never glitch.
module pwm_leds #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  input  logic                read_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_irq_out
);

  localparam logic [3:0]       OFF_CTRL     = 4'h0;
  localparam logic [3:0]       OFF_PRESCALE = 4'h1;
  localparam logic [3:0]       OFF_STATUS   = 4'h2;
  localparam logic [3:0]       OFF_COUNT    = 4'h3;
  localparam logic [3:0]       OFF_DUTY0    = 4'h4;
  localparam logic [WIDTH-1:0] COUNT_MAX    = '1;

  logic [1:0]          ctrl_q, ctrl_d;
  logic [15:0]         prescale_q, prescale_d;
  logic                wrap_q, wrap_d;
  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    duty_q [CHANNELS];
  logic [WIDTH-1:0]    duty_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  logic [3:0]  offset;
  logic        wr_en;
  logic        enable;
  logic        tick;
  logic        wrap_evt;
  logic [15:0] lane_bits;
  logic [31:0] rdata;
  logic        unused_bits;

  assign offset    = address_in[5:2];
  assign wr_en     = sel_in & (|write_mask_in);
  assign enable    = ctrl_q[0];
  assign tick      = enable & (pre_cnt_q == prescale_q);
  assign wrap_evt  = tick & (count_q == COUNT_MAX);
  assign lane_bits = {{8{write_mask_in[1]}}, {8{write_mask_in[0]}}};

  // Register write path; a wrap event overrides a same-cycle STATUS clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    wrap_d     = wrap_q;
    duty_d     = duty_q;
    if (wr_en) begin
      case (offset)
        OFF_CTRL:     if (write_mask_in[0]) ctrl_d = write_value_in[1:0];
        OFF_PRESCALE: prescale_d = (prescale_q & ~lane_bits) | (write_value_in[15:0] & lane_bits);
        OFF_STATUS:   if (write_mask_in[0] && write_value_in[0]) wrap_d = 1'b0;
        default:      ;
      endcase
      for (int n = 0; n < CHANNELS; n++) begin
        if (offset == OFF_DUTY0 + 4'(n)) begin
          duty_d[n] = (duty_q[n] & ~lane_bits[WIDTH-1:0])
                    | (write_value_in[WIDTH-1:0] & lane_bits[WIDTH-1:0]);
        end
      end
    end
    if (wrap_evt) wrap_d = 1'b1;
  end

  // Timebase and output compare; shadows load the pre-write DUTY value on wrap.
  always_comb begin
    pre_cnt_d = '0;
    count_d   = '0;
    shadow_d  = duty_q;
    pwm_d     = '0;
    if (enable) begin
      pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
      count_d   = tick ? count_q + 1'b1 : count_q;
      if (!wrap_evt) shadow_d = shadow_q;
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_d[n] = count_q < shadow_q[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      wrap_q     <= 1'b0;
      pre_cnt_q  <= '0;
      count_q    <= '0;
      pwm_q      <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        duty_q[n]   <= '0;
        shadow_q[n] <= '0;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      wrap_q     <= wrap_d;
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      pwm_q      <= pwm_d;
      duty_q     <= duty_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:     rdata[1:0]       = ctrl_q;
      OFF_PRESCALE: rdata[15:0]      = prescale_q;
      OFF_STATUS:   rdata[0]         = wrap_q;
      OFF_COUNT:    rdata[WIDTH-1:0] = count_q;
      default:      ;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (offset == OFF_DUTY0 + 4'(n)) rdata[WIDTH-1:0] = duty_q[n];
    end
  end

  // Bus is OR-combined upstream, so drive zero when not selected.
  assign read_value_out = sel_in ? rdata : 32'd0;
  assign ready_out      = sel_in;
  assign pwm_out        = pwm_q;
  assign period_irq_out = wrap_q & ctrl_q[1];

  assign unused_bits = ^{read_in, address_in[31:6], address_in[1:0], write_value_in[31:16]};

endmodule

// File: tb/tb_pwm_leds.sv
// tb/tb_pwm_leds.sv - directed self-checking bench for pwm_leds
module tb_pwm_leds;
  localparam int CHANNELS = 8;
  localparam int WIDTH    = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         address_in;
  logic                sel_in;
  logic                read_in;
  logic [31:0]         read_value_out;
  logic [3:0]          write_mask_in;
  logic [31:0]         write_value_in;
  logic                ready_out;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_irq_out;

  int total = 0;
  int bad   = 0;

  pwm_leds #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .pwm_out        (pwm_out),
    .period_irq_out (period_irq_out)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] mask);
    address_in     = 32'h0004_0000 | {26'd0, off, 2'b00};
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = mask;
    write_value_in = data;
    @(posedge clk);
    #1;
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    address_in    = 32'h0004_0000 | {26'd0, off, 2'b00};
    sel_in        = 1'b1;
    read_in       = 1'b1;
    write_mask_in = 4'h0;
    #1;
    data    = read_value_out;
    sel_in  = 1'b0;
    read_in = 1'b0;
  endtask

  // Polls COUNT once per cycle until it equals target; returns 0 on timeout.
  task automatic wait_count(input logic [31:0] target, output bit found);
    logic [31:0] d;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(posedge clk);
      #1;
      bus_read(4'h3, d);
      if (d == target) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL reset_read off=%0d got=%h want=0", i, d);
      end
    end
    total++;
    if (pwm_out !== '0 || period_irq_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs pwm=%h irq=%b want 0/0", pwm_out, period_irq_out);
    end
    bus_write(4'h0, 32'd1, 4'h0);
    bus_read(4'h0, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL mask0_write got=%h want=0", d);
    end
    sel_in = 1'b1;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL ready_hi got=%b want=1", ready_out);
    end
    sel_in = 1'b0;
    #1;
    total++;
    if (ready_out !== 1'b0) begin
      bad++;
      $display("FAIL ready_lo got=%b want=0", ready_out);
    end
    bus_write(4'hC, 32'hFF, 4'hF);
    bus_write(4'h3, 32'h55, 4'hF);
    bus_read(4'hC, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL unmapped_write got=%h want=0", d);
    end
    bus_read(4'h3, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL count_readonly got=%h want=0", d);
    end
  endtask

  task automatic test_basic_duty;
    logic [31:0] d;
    int h0, h1;
    bus_write(4'h0, 32'd0, 4'h1);
    bus_write(4'h1, 32'd0, 4'h3);
    bus_write(4'h4, 32'd64, 4'h1);
    bus_write(4'h5, 32'd0, 4'h1);
    bus_write(4'h0, 32'd1, 4'h1);
    bus_read(4'h3, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL count_at_enable got=%0d want=0", d);
    end
    repeat (10) @(posedge clk);
    #1;
    bus_read(4'h3, d);
    total++;
    if (d !== 32'd10) begin
      bad++;
      $display("FAIL count_after10 got=%0d want=10", d);
    end
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
    end
    total++;
    if (h0 != 64) begin
      bad++;
      $display("FAIL duty64_high got=%0d want=64", h0);
    end
    total++;
    if (h1 != 0) begin
      bad++;
      $display("FAIL duty0_high got=%0d want=0", h1);
    end
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    int h0, h2;
    bus_write(4'h0, 32'd0, 4'h1);
    bus_write(4'h1, 32'd3, 4'h3);
    bus_write(4'h6, 32'd255, 4'h1);
    bus_read(4'h1, d);
    total++;
    if (d !== 32'd3) begin
      bad++;
      $display("FAIL prescale_read got=%0d want=3", d);
    end
    bus_write(4'h0, 32'd1, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    bus_read(4'h3, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL prescale_pre_tick got=%0d want=0", d);
    end
    @(posedge clk);
    #1;
    bus_read(4'h3, d);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL prescale_first_tick got=%0d want=1", d);
    end
    h0 = 0;
    h2 = 0;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk);
      #1;
      h0 += int'(pwm_out[0]);
      h2 += int'(pwm_out[2]);
    end
    total++;
    if (h2 != 1020) begin
      bad++;
      $display("FAIL duty255_high got=%0d want=1020", h2);
    end
    total++;
    if (h0 != 256) begin
      bad++;
      $display("FAIL duty64_ps3_high got=%0d want=256", h0);
    end
    bus_write(4'h0, 32'd0, 4'h1);
    @(posedge clk);
    #1;
    bus_read(4'h3, d);
    total++;
    if (pwm_out !== '0 || d !== 32'd0) begin
      bad++;
      $display("FAIL disable pwm=%h count=%0d want 0/0", pwm_out, d);
    end
  endtask

  task automatic test_duty_update;
    bit found;
    int h;
    bus_write(4'h1, 32'd0, 4'h3);
    bus_write(4'h4, 32'd64, 4'h1);
    bus_write(4'h0, 32'd1, 4'h1);
    wait_count(32'd128, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_count128 got=timeout want=found");
    end
    bus_write(4'h4, 32'd200, 4'h1);
    h = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      logic [31:0] d;
      @(posedge clk);
      #1;
      h += int'(pwm_out[0]);
      bus_read(4'h3, d);
      if (d == 32'd0) found = 1'b1;
    end
    total++;
    if (!found || h != 0) begin
      bad++;
      $display("FAIL old_duty_tail got=%0d found=%0d want=0 found=1", h, found);
    end
    h = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      h += int'(pwm_out[0]);
    end
    total++;
    if (h != 200) begin
      bad++;
      $display("FAIL new_duty_high got=%0d want=200", h);
    end
    wait_count(32'd255, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_count255 got=timeout want=found");
    end
    bus_write(4'h4, 32'd30, 4'h1);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      h += int'(pwm_out[0]);
    end
    total++;
    if (h != 200) begin
      bad++;
      $display("FAIL wrap_write_deferred got=%0d want=200", h);
    end
    h = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      h += int'(pwm_out[0]);
    end
    total++;
    if (h != 30) begin
      bad++;
      $display("FAIL wrap_write_applied got=%0d want=30", h);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bit found;
    bus_write(4'h0, 32'd0, 4'h1);
    bus_write(4'h2, 32'd1, 4'h1);
    bus_write(4'h1, 32'd0, 4'h3);
    bus_write(4'h0, 32'd3, 4'h1);
    bus_read(4'h2, d);
    total++;
    if (d !== 32'd0 || period_irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_idle status=%0d irq=%b want 0/0", d, period_irq_out);
    end
    address_in = 32'h0004_0000;
    sel_in = 1'b0;
    #1;
    total++;
    if (read_value_out !== 32'd0) begin
      bad++;
      $display("FAIL unselected_read got=%h want=0", read_value_out);
    end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #1;
      if (period_irq_out === 1'b1) found = 1'b1;
    end
    bus_read(4'h2, d);
    total++;
    if (!found || d !== 32'd1) begin
      bad++;
      $display("FAIL irq_after_wrap status=%0d found=%0d want 1/1", d, found);
    end
    bus_write(4'h2, 32'd1, 4'h1);
    bus_read(4'h2, d);
    total++;
    if (d !== 32'd0 || period_irq_out !== 1'b0) begin
      bad++;
      $display("FAIL status_clear status=%0d irq=%b want 0/0", d, period_irq_out);
    end
    wait_count(32'd255, found);
    bus_write(4'h2, 32'd1, 4'h1);
    bus_read(4'h2, d);
    total++;
    if (!found || d !== 32'd1 || period_irq_out !== 1'b1) begin
      bad++;
      $display("FAIL clear_on_wrap status=%0d irq=%b want 1/1", d, period_irq_out);
    end
    bus_write(4'h0, 32'd1, 4'h1);
    total++;
    if (period_irq_out !== 1'b0) begin
      bad++;
      $display("FAIL irq_masked got=%b want=0", period_irq_out);
    end
  endtask

  task automatic test_reset_mid_period;
    logic [31:0] d;
    bit found;
    bus_write(4'h0, 32'd0, 4'h1);
    bus_write(4'h1, 32'd0, 4'h3);
    bus_write(4'h4, 32'd200, 4'h1);
    bus_write(4'h0, 32'd3, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out[0] === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL pwm_high_before_reset got=timeout want=high");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (pwm_out !== '0 || period_irq_out !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_outputs pwm=%h irq=%b want 0/0", pwm_out, period_irq_out);
    end
    for (int i = 0; i < 12; i++) begin
      bus_read(4'(i), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL post_reset_read off=%0d got=%h want=0", i, d);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    address_in     = 32'd0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_basic_duty;
    test_prescale;
    test_duty_update;
    test_irq;
    test_reset_mid_period;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
